tcp_mss_negotiator: RTL
=======================

// Module: tcp_mss_negotiator
// PURPOSE
//  Multi-connection successor to the scalar MSS negotiation function. Takes the MSS
//  option from incoming SYNs and computes the negotiated MSS against a local limit.
//  Stores the result per connection and returns it on a registered response channel.
//  Sits between the TCP option parser and the segmenter, which reads per-connection
//  MSS through the lookup port.
// PARAMETERS
//  NUM_CONN       8      number of connection slots; CONN_W = max(1,$clog2(NUM_CONN))
//  MSS_W          16     MSS field width
//  DEFAULT_MSS    536    used when MSS option is absent or zero
//  LOCAL_MAX_MSS  536    upper bound on negotiated MSS; 536/536 gives legacy behaviour
//  MIN_MSS        64     lower bound; applies only with TCP_MSS_MIN_CLAMP_EN
// PORTS
//  clk             in   1        clock
//  rst_n           in   1        synchronous active-low reset
//  req_valid       in   1        negotiation request valid
//  req_ready       out  1        request accepted when valid&&ready
//  req_conn_id     in   CONN_W   connection slot
//  req_mss_present in   1        SYN carried an MSS option
//  req_client_mss  in   MSS_W    client MSS value
//  rsp_valid       out  1        response valid
//  rsp_ready       in   1        downstream ready
//  rsp_conn_id     out  CONN_W   echoed slot
//  rsp_mss         out  MSS_W    negotiated MSS
//  rsp_err         out  1        conn_id >= NUM_CONN; rsp_mss = DEFAULT_MSS, no table write
//  clr_valid       in   1        invalidate slot clr_conn_id (connection closed)
//  clr_conn_id     in   CONN_W   slot to invalidate
//  lkp_conn_id     in   CONN_W   lookup slot
//  lkp_mss         out  MSS_W    stored MSS, 1-cycle latency; DEFAULT_MSS if slot invalid
//  lkp_hit         out  1        slot valid, 1-cycle latency
//  reduced_cnt     out  16       saturating count of requests where client MSS was lowered
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): rsp_valid=0, rsp_conn_id=0, rsp_mss=0, rsp_err=0.
//   Also: lkp_mss=DEFAULT_MSS, lkp_hit=0, reduced_cnt=0, all slot valid bits=0.
//   Reset mid-transaction drops any pending response.
//  Arithmetic, unsigned MSS_W compare:
//   m = (!present || client==0) ? DEFAULT_MSS : min(client, LOCAL_MAX_MSS).
//   reduced = present && client>LOCAL_MAX_MSS.
//  Response register, FSM EMPTY/FULL:
//   req_ready = (state==EMPTY) || rsp_ready; handshake is same-cycle pass-through.
//   EMPTY -> FULL on accept.
//   FULL -> EMPTY on rsp_ready with no accept.
//   FULL stays FULL on rsp_ready with accept; rsp_* are reloaded.
//   FULL stays FULL on !rsp_ready and holds rsp_* stable.
//  Latency: accept at cycle N -> rsp_valid at N+1; full throughput of 1 req/cycle.
//  Table write: on accept with id<NUM_CONN, write m to slot and set its valid bit
//   in the same edge.
//  Clear: clears the valid bit. Clear and accepted write to the same slot in the same
//   cycle: write wins (slot valid, new MSS). Clear of an out-of-range id is ignored.
//  Lookup is read-before-write: a same-cycle write to lkp_conn_id is visible in lkp_*
//   one cycle later, not in the same cycle. An out-of-range lkp id gives
//   lkp_hit=0 and DEFAULT_MSS.
//  reduced_cnt increments by 1 per accepted request with reduced=1 and saturates at
//   16'hFFFF. Error requests (id>=NUM_CONN) do not count.
// CONFIGURATION
//  TCP_MSS_MIN_CLAMP_EN defined:
//   Present, nonzero client MSS below MIN_MSS gives m = MIN_MSS (not counted as reduced).
//   Stored value and rsp_mss are both clamped.
//  TCP_MSS_MIN_CLAMP_EN undefined:
//   No lower clamp; any nonzero client MSS below LOCAL_MAX_MSS passes unchanged.
//   MIN_MSS is unused.
// TESTING
//  1 Defaults: req id=2, present=1, client=1460 -> next cycle rsp_mss=536, rsp_conn_id=2,
//    reduced_cnt=1. lkp id=2 -> lkp_hit=1, lkp_mss=536.
//  2 Absent/zero: present=0 -> 536; present=1, client=0 -> 536, reduced_cnt unchanged.
//    client=300 -> 300.
//  3 Backpressure: rsp_ready=0 with 2 requests -> first held stable, req_ready=0 until
//    rsp_ready=1. Then second response next cycle; no loss or duplication.
//  4 Clear/write collision: same cycle clr id=3 and write id=3, client=400 ->
//    lkp id=3 gives hit=1, mss=400. Later clr-only -> hit=0, mss=536.
//  5 Min clamp, client=20: with TCP_MSS_MIN_CLAMP_EN -> rsp_mss=64; without -> 20.
//  6 Reset mid-FULL: rsp_valid=1, assert rst_n=0 one cycle -> rsp_valid=0, lkp_hit=0
//    for all slots, reduced_cnt=0.

Source files
------------

// File: rtl/tcp_mss_negotiator.sv
// Per-connection TCP MSS negotiation with a one-deep registered response and a lookup port.
// Optional lower clamp to MIN_MSS is enabled by defining TCP_MSS_MIN_CLAMP_EN.
module tcp_mss_negotiator #(
    parameter  int NUM_CONN      = 8,
    parameter  int MSS_W         = 16,
    parameter  int DEFAULT_MSS   = 536,
    parameter  int LOCAL_MAX_MSS = 536,
    parameter  int MIN_MSS       = 64,
    localparam int CONN_W        = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CONN_W-1:0] req_conn_id,
    input  logic              req_mss_present,
    input  logic [MSS_W-1:0]  req_client_mss,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CONN_W-1:0] rsp_conn_id,
    output logic [MSS_W-1:0]  rsp_mss,
    output logic              rsp_err,
    input  logic              clr_valid,
    input  logic [CONN_W-1:0] clr_conn_id,
    input  logic [CONN_W-1:0] lkp_conn_id,
    output logic [MSS_W-1:0]  lkp_mss,
    output logic              lkp_hit,
    output logic [15:0]       reduced_cnt
);

`ifdef TCP_MSS_MIN_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    localparam logic [MSS_W-1:0] DEF_M = MSS_W'(DEFAULT_MSS);
    localparam logic [MSS_W-1:0] MAX_M = MSS_W'(LOCAL_MAX_MSS);
    // A floor of 1 is a no-op: a zero client MSS has already selected the default.
    localparam logic [MSS_W-1:0] FLOOR_M = CLAMP_EN ? MSS_W'(MIN_MSS) : MSS_W'(1);

    typedef enum logic {EMPTY, FULL} state_t;

    function automatic logic [MSS_W-1:0] negotiate(input logic present,
                                                   input logic [MSS_W-1:0] client);
        if (!present || client == '0) return DEF_M;
        if (client < FLOOR_M)         return FLOOR_M;
        if (client > MAX_M)           return MAX_M;
        return client;
    endfunction

    function automatic logic is_reduced(input logic present, input logic [MSS_W-1:0] client);
        return present && (client > MAX_M);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    state_t             state;
    logic [MSS_W-1:0]   mss_tab [NUM_CONN];
    logic [NUM_CONN-1:0] slot_vld;

    logic             accept;
    logic             req_err;
    logic             wr_en;
    logic             clr_in;
    logic             lkp_in;
    logic [MSS_W-1:0] req_m;

    assign req_ready = (state == EMPTY) || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign req_err   = int'(req_conn_id) >= NUM_CONN;
    assign wr_en     = accept && !req_err;
    assign clr_in    = int'(clr_conn_id) < NUM_CONN;
    assign lkp_in    = int'(lkp_conn_id) < NUM_CONN;
    assign req_m     = req_err ? DEF_M : negotiate(req_mss_present, req_client_mss);

    always_ff @(posedge clk) begin
        if (wr_en) mss_tab[req_conn_id] <= req_m;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            rsp_valid   <= 1'b0;
            rsp_conn_id <= '0;
            rsp_mss     <= '0;
            rsp_err     <= 1'b0;
            lkp_mss     <= DEF_M;
            lkp_hit     <= 1'b0;
            slot_vld    <= '0;
            reduced_cnt <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    state     <= FULL;
                    rsp_valid <= 1'b1;
                end
                FULL: if (rsp_ready && !accept) begin
                    state     <= EMPTY;
                    rsp_valid <= 1'b0;
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                rsp_conn_id <= req_conn_id;
                rsp_mss     <= req_m;
                rsp_err     <= req_err;
            end
            // Lookup samples the table before this edge's clear/write take effect.
            lkp_hit <= lkp_in && slot_vld[lkp_conn_id];
            lkp_mss <= (lkp_in && slot_vld[lkp_conn_id]) ? mss_tab[lkp_conn_id] : DEF_M;
            if (clr_valid && clr_in) slot_vld[clr_conn_id] <= 1'b0;
            if (wr_en)               slot_vld[req_conn_id] <= 1'b1;
            if (wr_en && is_reduced(req_mss_present, req_client_mss))
                reduced_cnt <= sat_inc(reduced_cnt);
        end
    end

endmodule
